// File: rtl/dco_fll_ctrl_if.sv
// Control/status bundle between the FLL controller and its host or testbench.
// count_valid is a strobe with no ready: it is high for exactly one clk cycle when count_out
// takes a new window result, cannot be back-pressured, and count_out holds until the next strobe.
interface dco_fll_ctrl_if #(
  parameter int CODE_W  = 6,
  parameter int RANGE_W = 2,
  parameter int CNT_W   = 12
);
  logic               en;
  logic               osc_in;
  logic [CNT_W-1:0]   target;
  logic [RANGE_W-1:0] range_init;
  logic [CODE_W-1:0]  code_out;
  logic [RANGE_W-1:0] range_out;
  logic [CNT_W-1:0]   count_out;
  logic               count_valid;
  logic               locked;
  logic               saturated;

  modport master (
    output en, osc_in, target, range_init,
    input  code_out, range_out, count_out, count_valid, locked, saturated
  );

  modport slave (
    input  en, osc_in, target, range_init,
    output code_out, range_out, count_out, count_valid, locked, saturated
  );
endinterface

// File: rtl/dco_fll_ctrl.sv
// Frequency-locked-loop controller for the ring-oscillator DCO: counts oscillator edges over a
// fixed gate window, then steps the fine code and coarse range so the count approaches target.
module dco_fll_ctrl #(
  parameter int CODE_W    = 6,
  parameter int RANGE_W   = 2,
  parameter int CNT_W     = 12,
  parameter int GATE_LOG2 = 10,
  parameter int LOCK_N    = 4,
  parameter int TOL       = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  dco_fll_ctrl_if.slave ctl_if,
  output logic [1:0]    dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_ADJUST  = 2'd2
  } state_e;

  localparam int LOCK_W = $clog2(LOCK_N + 1);

  localparam logic [CODE_W-1:0]    CODE_MID  = CODE_W'(1) << (CODE_W - 1);
  localparam logic [CODE_W-1:0]    CODE_MAX  = '1;
  localparam logic [CODE_W-1:0]    CODE_MIN  = '0;
  localparam logic [RANGE_W-1:0]   RANGE_MAX = '1;
  localparam logic [RANGE_W-1:0]   RANGE_MIN = '0;
  localparam logic [CNT_W-1:0]     EDGE_MAX  = '1;
  localparam logic [GATE_LOG2-1:0] GATE_LAST = '1;
  localparam logic [LOCK_W-1:0]    LOCK_MAX  = LOCK_W'(LOCK_N);
  localparam logic signed [CNT_W:0] TOL_P    = (CNT_W + 1)'(TOL);
  localparam logic signed [CNT_W:0] TOL_N    = -TOL_P;

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q, sync3_q;
  logic [GATE_LOG2-1:0] gate_q, gate_d;
  logic [CNT_W-1:0]     edge_q, edge_d;
  logic [CODE_W-1:0]    code_q, code_d;
  logic [RANGE_W-1:0]   range_q, range_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 valid_q, valid_d;
  logic                 locked_q, locked_d;
  logic                 sat_q, sat_d;
  logic [LOCK_W-1:0]    lock_cnt_q, lock_cnt_d;

  logic                 rise;
  logic [CNT_W-1:0]     edge_next;
  logic [LOCK_W-1:0]    lock_inc;
  logic signed [CNT_W:0] err;
  logic                 too_slow;
  logic                 too_fast;

  // osc_in is asynchronous: two flops resolve metastability, the third gives the edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= ctl_if.osc_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rise = sync2_q & ~sync3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gate_q     <= '0;
      edge_q     <= '0;
      code_q     <= CODE_MID;
      range_q    <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      sat_q      <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gate_q     <= gate_d;
      edge_q     <= edge_d;
      code_q     <= code_d;
      range_q    <= range_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      sat_q      <= sat_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // The edge counter sticks at full scale so an over-fast oscillator reads as "too fast", not small.
  assign edge_next = (rise && (edge_q != EDGE_MAX)) ? edge_q + CNT_W'(1) : edge_q;
  assign lock_inc  = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + LOCK_W'(1);
  assign err       = $signed({1'b0, ctl_if.target}) - $signed({1'b0, count_q});
  assign too_slow  = (err > TOL_P);
  assign too_fast  = (err < TOL_N);

  always_comb begin
    state_d    = state_q;
    gate_d     = gate_q;
    edge_d     = edge_q;
    code_d     = code_q;
    range_d    = range_q;
    count_d    = count_q;
    valid_d    = 1'b0;
    locked_d   = locked_q;
    sat_d      = sat_q;
    lock_cnt_d = lock_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (ctl_if.en) begin
          state_d    = S_MEASURE;
          range_d    = ctl_if.range_init;
          code_d     = CODE_MID;
          locked_d   = 1'b0;
          sat_d      = 1'b0;
          gate_d     = '0;
          edge_d     = '0;
          lock_cnt_d = '0;
        end
      end

      S_MEASURE: begin
        if (!ctl_if.en) begin
          state_d    = S_IDLE;
          locked_d   = 1'b0;
          gate_d     = '0;
          edge_d     = '0;
          lock_cnt_d = '0;
        end else if (gate_q == GATE_LAST) begin
          // The edge seen on the last gate cycle still belongs to this window.
          count_d = edge_next;
          valid_d = 1'b1;
          state_d = S_ADJUST;
          gate_d  = '0;
          edge_d  = '0;
        end else begin
          gate_d = gate_q + GATE_LOG2'(1);
          edge_d = edge_next;
        end
      end

      S_ADJUST: begin
        if (!ctl_if.en) begin
          state_d    = S_IDLE;
          locked_d   = 1'b0;
          lock_cnt_d = '0;
        end else begin
          state_d = S_MEASURE;
          gate_d  = '0;
          edge_d  = '0;
          if (too_slow) begin
            lock_cnt_d = '0;
            locked_d   = 1'b0;
            sat_d      = 1'b0;
            if (code_q != CODE_MAX) begin
              code_d = code_q + CODE_W'(1);
            end else if (range_q != RANGE_MAX) begin
              range_d = range_q + RANGE_W'(1);
              code_d  = CODE_MID;
            end else begin
              sat_d = 1'b1;
            end
          end else if (too_fast) begin
            lock_cnt_d = '0;
            locked_d   = 1'b0;
            sat_d      = 1'b0;
            if (code_q != CODE_MIN) begin
              code_d = code_q - CODE_W'(1);
            end else if (range_q != RANGE_MIN) begin
              range_d = range_q - RANGE_W'(1);
              code_d  = CODE_MID;
            end else begin
              sat_d = 1'b1;
            end
          end else begin
            lock_cnt_d = lock_inc;
            locked_d   = (lock_inc == LOCK_MAX);
            sat_d      = 1'b0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ctl_if.code_out    = code_q;
  assign ctl_if.range_out   = range_q;
  assign ctl_if.count_out   = count_q;
  assign ctl_if.count_valid = valid_q;
  assign ctl_if.locked      = locked_q;
  assign ctl_if.saturated   = sat_q;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_dco_fll_ctrl.sv
// Bench for dco_fll_ctrl: static counts from a vector table, closed loop against a DCO model,
// range rollover/saturation sweeps, abort, counter saturation and asynchronous reset.
module tb_dco_fll_ctrl;

  localparam int TOL    = 1;
  localparam int LOCK_N = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dco_fll_ctrl_if                 m_if ();
  dco_fll_ctrl_if #(.CNT_W(8))    s_if ();
  dco_fll_ctrl_if                 f_if ();
  logic [1:0] m_state, s_state, f_state;

  dco_fll_ctrl u_dut (.clk(clk), .rst_n(rst_n), .ctl_if(m_if.slave), .dbg_state_o(m_state));
  dco_fll_ctrl #(.CNT_W(8)) u_sat (.clk(clk), .rst_n(rst_n), .ctl_if(s_if.slave), .dbg_state_o(s_state));
  dco_fll_ctrl #(.GATE_LOG2(4)) u_fast (.clk(clk), .rst_n(rst_n), .ctl_if(f_if.slave), .dbg_state_o(f_state));

  int n_cmp  = 0;
  int n_fail = 0;

  // Oscillator stimulus: 0 = low, 1 = fixed divider, 2 = DCO model, 3 = random.
  int m_mode = 0, m_half = 4, m_div = 0, m_acc = 0;
  int f_mode = 0, f_div = 0;
  bit s_run  = 1'b0;
  int mdl_code[3], mdl_range[3], streak[3];
  logic [9:0] exp_q[$];
  logic [11:0] cnt_q[$];

  // DCO model: period in quarter clk cycles is 16 + 64*range + (63 - code).
  always @(negedge clk) begin
    case (m_mode)
      1: begin
        m_div = m_div + 1;
        if (m_div >= m_half) begin m_div = 0; m_if.osc_in = ~m_if.osc_in; end
      end
      2: begin
        m_acc = m_acc + 8;
        if (m_acc >= 16 + mdl_range[0] * 64 + (63 - mdl_code[0])) begin
          m_acc = m_acc - (16 + mdl_range[0] * 64 + (63 - mdl_code[0]));
          m_if.osc_in = ~m_if.osc_in;
        end
      end
      3: m_if.osc_in = 1'($urandom_range(0, 1));
      default: m_if.osc_in = 1'b0;
    endcase
    s_if.osc_in = s_run ? ~s_if.osc_in : 1'b0;
    if (f_mode == 1) begin
      f_div = f_div + 1;
      if (f_div >= 2) begin f_div = 0; f_if.osc_in = ~f_if.osc_in; end
    end else begin
      f_if.osc_in = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_valid(input int which, input int budget, output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (n < budget && !ok) begin
      tick(1);
      n++;
      case (which)
        0:       ok = m_if.count_valid;
        1:       ok = s_if.count_valid;
        default: ok = f_if.count_valid;
      endcase
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_valid_%0d: no count_valid within %0d cycles, expected a pulse", which, budget);
    end
  endtask

  task automatic get_outs(input int which, output int code, output int rng, output int cnt,
                          output int lk, output int sat);
    case (which)
      0: begin code = m_if.code_out; rng = m_if.range_out; cnt = m_if.count_out;
               lk = m_if.locked; sat = m_if.saturated; end
      1: begin code = s_if.code_out; rng = s_if.range_out; cnt = s_if.count_out;
               lk = s_if.locked; sat = s_if.saturated; end
      default: begin code = f_if.code_out; rng = f_if.range_out; cnt = f_if.count_out;
               lk = f_if.locked; sat = f_if.saturated; end
    endcase
  endtask

  // Reference adjustment rule for one window with error err = target - count.
  task automatic model_adjust(input int err, input int code_i, input int rng_i, input int stk_i,
                              output int code_o, output int rng_o, output int stk_o,
                              output bit sat_o, output bit lk_o);
    code_o = code_i; rng_o = rng_i; stk_o = stk_i; sat_o = 1'b0; lk_o = 1'b0;
    if (err > TOL) begin
      stk_o = 0;
      if (code_i < 63) code_o = code_i + 1;
      else if (rng_i < 3) begin rng_o = rng_i + 1; code_o = 32; end
      else sat_o = 1'b1;
    end else if (err < -TOL) begin
      stk_o = 0;
      if (code_i > 0) code_o = code_i - 1;
      else if (rng_i > 0) begin rng_o = rng_i - 1; code_o = 32; end
      else sat_o = 1'b1;
    end else begin
      if (stk_i < LOCK_N) stk_o = stk_i + 1;
      lk_o = (stk_o >= LOCK_N);
    end
  endtask

  task automatic run_windows(input int which, input int tgt, input int max_win,
                             input bit stop_on_lock, output bit got_lock);
    int n, code, rng, cnt, lk, sat, err, p4, c_n, r_n, s_n, held;
    bit ok, sat_n, lk_n;
    logic [9:0] e;
    got_lock = 1'b0; held = 0;
    if (which == 0) m_if.target = 12'(tgt);
    else f_if.target = 12'(tgt);
    for (int w = 0; w < max_win; w++) begin
      if (stop_on_lock && held >= 3) break;
      wait_valid(which, 1100, n, ok);
      if (!ok) break;
      get_outs(which, code, rng, cnt, lk, sat);
      if (which == 0) begin
        p4 = 16 + mdl_range[0] * 64 + (63 - mdl_code[0]);
        chk_rng("loop_count_x_period", cnt * p4 - 4096, -2 * p4, 2 * p4);
      end else if (f_mode == 0) begin
        chk("sweep_count_quiet", cnt, 0);
      end else begin
        chk_rng("sweep_count_fast", cnt, 2, 5);
      end
      err = tgt - cnt;
      model_adjust(err, mdl_code[which], mdl_range[which], streak[which],
                   c_n, r_n, s_n, sat_n, lk_n);
      exp_q.push_back({sat_n, lk_n, r_n[1:0], c_n[5:0]});
      tick(1);
      e = exp_q.pop_front();
      get_outs(which, code, rng, cnt, lk, sat);
      chk("adj_code", code, int'(e[5:0]));
      chk("adj_range", rng, int'(e[7:6]));
      chk("adj_locked", lk, int'(e[8]));
      chk("adj_saturated", sat, int'(e[9]));
      mdl_code[which] = c_n; mdl_range[which] = r_n; streak[which] = s_n;
      if (lk_n) begin got_lock = 1'b1; held++; end
    end
  endtask

  typedef struct {
    int half;
    int rinit;
    int exp_cnt;
  } vec_t;
  vec_t vecs[4];

  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not finish in time, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pulses, code, rng, cnt, lk, sat;
    bit ok, got;
    logic [11:0] e;

    vecs[0] = '{half: 4, rinit: 1, exp_cnt: 128};
    vecs[1] = '{half: 2, rinit: 2, exp_cnt: 256};
    vecs[2] = '{half: 8, rinit: 3, exp_cnt: 64};
    vecs[3] = '{half: 3, rinit: 0, exp_cnt: 171};

    // Reset held with the loop enabled and a random oscillator.
    rst_n = 1'b0;
    m_mode = 3;
    m_if.en = 1'b1; m_if.target = 12'd150; m_if.range_init = 2'd2;
    s_if.en = 1'b0; s_if.target = 8'd0;    s_if.range_init = 2'd0;
    f_if.en = 1'b0; f_if.target = 12'd0;   f_if.range_init = 2'd0;
    tick(6);
    chk("rst_code", m_if.code_out, 32);
    chk("rst_range", m_if.range_out, 0);
    chk("rst_count", m_if.count_out, 0);
    chk("rst_valid", m_if.count_valid, 0);
    chk("rst_locked", m_if.locked, 0);
    chk("rst_saturated", m_if.saturated, 0);
    chk("rst_state", m_state, 0);

    m_if.en = 1'b0;
    rst_n = 1'b1;
    tick(4);
    chk("idle_code", m_if.code_out, 32);
    chk("idle_range", m_if.range_out, 0);
    chk("idle_state", m_state, 0);

    // Static counts from the vector table.
    m_mode = 1;
    for (int i = 0; i < 4; i++) begin
      m_if.en = 1'b0;
      tick(2);
      m_half = vecs[i].half;
      m_if.range_init = 2'(vecs[i].rinit);
      m_if.target = 12'(vecs[i].exp_cnt);
      m_if.en = 1'b1;
      tick(1);
      chk("static_range", m_if.range_out, vecs[i].rinit);
      chk("static_code_mid", m_if.code_out, 32);
      chk("static_state", m_state, 1);
      cnt_q.push_back(12'(vecs[i].exp_cnt));
      wait_valid(0, 1100, n, ok);
      e = cnt_q.pop_front();
      if (ok) begin
        chk_rng("static_latency", n + 1, 1025, 1026);
        chk_rng("static_count", m_if.count_out, int'(e) - 1, int'(e) + 1);
      end
      tick(1);
      chk("valid_pulse_width", m_if.count_valid, 0);
      chk("static_code_hold", m_if.code_out, 32);
    end

    // Abort mid-window after one adjustment has moved the code.
    m_if.en = 1'b0;
    tick(2);
    m_half = 4; m_if.target = 12'd4000; m_if.range_init = 2'd2;
    m_if.en = 1'b1;
    wait_valid(0, 1200, n, ok);
    tick(1);
    chk("abort_pre_code", m_if.code_out, 33);
    chk("abort_pre_range", m_if.range_out, 2);
    tick(499);
    m_if.en = 1'b0;
    tick(1);
    chk("abort_state", m_state, 0);
    chk("abort_code_kept", m_if.code_out, 33);
    chk("abort_range_kept", m_if.range_out, 2);
    chk("abort_locked", m_if.locked, 0);
    pulses = 0;
    repeat (1100) begin
      tick(1);
      if (m_if.count_valid) pulses++;
    end
    chk("abort_no_valid", pulses, 0);
    chk("abort_code_still", m_if.code_out, 33);

    // Closed loop against the DCO model, then a target step and relock.
    mdl_code[0] = 32; mdl_range[0] = 0; streak[0] = 0;
    m_acc = 0; m_mode = 2;
    m_if.range_init = 2'd0; m_if.target = 12'd152;
    m_if.en = 1'b1;
    tick(1);
    run_windows(0, 152, 45, 1'b1, got);
    chk("loop_lock_reached", int'(got), 1);
    run_windows(0, 205, 30, 1'b1, got);
    chk("relock_reached", int'(got), 1);

    // Edge counter saturation with osc at clk/2 and an 8-bit counter.
    s_run = 1'b1;
    s_if.en = 1'b1;
    wait_valid(1, 1100, n, ok);
    chk("count_saturates", s_if.count_out, 255);
    s_if.en = 1'b0;
    s_run = 1'b0;

    // Short-window instance: sweep up through every range into saturation, then back down.
    mdl_code[2] = 32; mdl_range[2] = 0; streak[2] = 0;
    f_mode = 0;
    f_if.range_init = 2'd0;
    f_if.en = 1'b1;
    tick(1);
    run_windows(2, 100, 130, 1'b0, got);
    get_outs(2, code, rng, cnt, lk, sat);
    chk("sweep_up_sat", sat, 1);
    chk("sweep_up_code", code, 63);
    chk("sweep_up_range", rng, 3);
    f_mode = 1;
    run_windows(2, 0, 165, 1'b0, got);
    get_outs(2, code, rng, cnt, lk, sat);
    chk("sweep_dn_sat", sat, 1);
    chk("sweep_dn_code", code, 0);
    chk("sweep_dn_range", rng, 0);

    // Asynchronous reset while the main loop is running and locked.
    tick(20);
    rst_n = 1'b0;
    #2;
    chk("async_rst_code", m_if.code_out, 32);
    chk("async_rst_range", m_if.range_out, 0);
    chk("async_rst_count", m_if.count_out, 0);
    chk("async_rst_locked", m_if.locked, 0);
    chk("async_rst_state", m_state, 0);
    chk("async_rst_f_sat", f_if.saturated, 0);
    m_if.en = 1'b0; f_if.en = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
